// File: rtl/uart_bus_master.sv
// Two-phase register bus initiator: turns single-word commands into setup/access
// transfers, waits for ready, aborts stalled accesses, and inserts an idle gap.
module uart_bus_master #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [9:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        sel,
  output logic        enable,
  output logic        write,
  output logic [9:0]  addr,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  input  logic        ready,
  output logic [1:0]  state_dbg
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // the response is a single-cycle rsp_valid pulse with no back-pressure.

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GAP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [3:0]  gap_q, gap_d;
  logic        cmd_ready_d, rsp_valid_d, rsp_err_d, sel_d, enable_d, write_d;
  logic [31:0] rsp_rdata_d, data_out_d;
  logic [9:0]  addr_d;

  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      gap_q     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      sel       <= 1'b0;
      enable    <= 1'b0;
      write     <= 1'b0;
      addr      <= '0;
      data_out  <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
      sel       <= sel_d;
      enable    <= enable_d;
      write     <= write_d;
      addr      <= addr_d;
      data_out  <= data_out_d;
    end
  end

  // Next-state logic computes the registered output values for the next cycle;
  // the output registers double as the latched command during the transfer.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata;
    sel_d       = sel;
    enable_d    = enable;
    write_d     = write;
    addr_d      = addr;
    data_out_d  = data_out;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          sel_d       = 1'b1;
          enable_d    = 1'b0;
          write_d     = cmd_write;
          addr_d      = cmd_addr;
          data_out_d  = cmd_write ? cmd_wdata : 32'd0;
        end
      end
      SETUP: begin
        state_d  = ACCESS;
        enable_d = 1'b1;
        tmo_d    = '0;
      end
      ACCESS: begin
        // ready wins over an expiring counter on the same edge
        if (ready || (tmo_q == TMO_LAST)) begin
          state_d     = GAP;
          gap_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !ready;
          if (ready && !write) rsp_rdata_d = data_in;
          sel_d       = 1'b0;
          enable_d    = 1'b0;
          write_d     = 1'b0;
          addr_d      = '0;
          data_out_d  = '0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: directed scenarios plus randomized
// commands against a transaction-level model of the expected bus behaviour.
module tb_uart_bus_master;

  localparam int GAP_CYCLES = 1;
  localparam int TIMEOUT    = 8;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        sel, enable, write;
  logic [9:0]  addr;
  logic [31:0] data_out, data_in;
  logic        ready;
  logic [1:0]  state_dbg;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_rdata = '0;
  logic [41:0] exp_q[$];

  uart_bus_master #(.GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .sel(sel), .enable(enable), .write(write), .addr(addr),
    .data_out(data_out), .data_in(data_in), .ready(ready),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One complete transfer; the peripheral asserts ready on access cycle delay+1
  // (never, if delay >= TIMEOUT). Called at a falling edge with the DUT idle.
  task automatic run_cmd(input logic wr, input logic [9:0] a, input logic [31:0] wd,
                         input int delay, input logic [31:0] rd);
    logic        exp_err;
    int          exp_en, n_en;
    logic [31:0] exp_do;
    exp_err = (delay >= TIMEOUT);
    exp_en  = exp_err ? TIMEOUT : delay + 1;
    exp_do  = wr ? wd : 32'd0;
    check("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 10'($urandom); cmd_wdata = $urandom;
    check("setup_sel", sel, 1);
    check("setup_en", enable, 0);
    check("setup_addr", addr, 32'(a));
    check("setup_dout", data_out, exp_do);
    check("setup_wr", write, 32'(wr));
    check("setup_rdy", cmd_ready, 0);
    ready = 1'($urandom); data_in = $urandom;
    n_en = 0;
    @(negedge clk);
    while (enable === 1'b1 && n_en < TIMEOUT + 2) begin
      if (addr !== a || data_out !== exp_do || sel !== 1'b1) check("access_hold", {addr, sel}, {a, 1'b1});
      n_en++;
      if (n_en - 1 == delay) begin ready = 1'b1; data_in = rd; end
      else begin ready = 1'b0; data_in = $urandom; end
      @(negedge clk);
    end
    ready = 1'($urandom); data_in = $urandom;
    check("en_cycles", n_en, exp_en);
    if (!wr && !exp_err) model_rdata = rd;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, 32'(exp_err));
    check("rsp_rdata", rsp_rdata, model_rdata);
    check("gap_sel", sel, 0);
    check("gap_addr", {addr, data_out}, 0);
    for (int g = 1; g < GAP_CYCLES; g++) begin
      @(negedge clk);
      check("gap_sel_n", sel, 0);
      check("gap_rsp_low", rsp_valid, 0);
    end
    @(negedge clk);
    check("back_idle", cmd_ready, 1);
    check("rsp_pulse", rsp_valid, 0);
  endtask

  task automatic back_to_back();
    logic [9:0]  a_tab[3];
    logic [31:0] d_tab[3];
    int          acc[$];
    int          idx, n_rsp;
    logic        prev_sel;
    logic [41:0] e;
    a_tab = '{10'd4, 10'd2, 10'd0};
    d_tab = '{32'd40, 32'd2, 32'd10};
    for (int i = 0; i < 3; i++) exp_q.push_back({a_tab[i], d_tab[i]});
    ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a_tab[0]; cmd_wdata = d_tab[0];
    idx = 1; n_rsp = 0; prev_sel = sel;
    for (int c = 0; c < 20; c++) begin
      if (cmd_valid && cmd_ready) acc.push_back(c);
      if (rsp_valid) n_rsp++;
      if (sel && !enable) begin
        check("b2b_sep", prev_sel, 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("b2b_addr", addr, 32'(e[41:32]));
          check("b2b_data", data_out, e[31:0]);
        end else check("b2b_extra", 1, 0);
        if (idx < 3) begin cmd_addr = a_tab[idx]; cmd_wdata = d_tab[idx]; end
        else cmd_valid = 1'b0;
        idx++;
      end
      prev_sel = sel;
      @(negedge clk);
    end
    ready = 1'b0;
    check("b2b_accepts", acc.size(), 3);
    check("b2b_rsps", n_rsp, 3);
    check("b2b_left", exp_q.size(), 0);
    for (int i = 1; i < acc.size(); i++) check("b2b_spacing", acc[i] - acc[i-1], 3 + GAP_CYCLES);
  endtask

  task automatic reset_mid_access();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'd0; cmd_wdata = '0;
    @(negedge clk);
    cmd_valid = 1'b0; ready = 1'b0;
    @(negedge clk);
    check("rst_pre_en", enable, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_sel", sel, 0);
    check("rst_en", enable, 0);
    check("rst_rsp", rsp_valid, 0);
    check("rst_rdy", cmd_ready, 1);
    model_rdata = '0;
    check("rst_rdata", rsp_rdata, model_rdata);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic        wr;
    logic [9:0]  a;
    int          dly;
    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    data_in = '0; ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdy", cmd_ready, 1);
    check("reset_sel_en", {sel, enable, write}, 0);
    check("reset_rsp", {rsp_valid, rsp_err}, 0);
    check("reset_rdata", rsp_rdata, 0);
    check("reset_bus", {addr, data_out}, 0);
    rst = 1'b1;
    @(negedge clk);

    run_cmd(1'b1, 10'd4, 32'd20, 0, 32'd0);         // write baud divisor
    run_cmd(1'b0, 10'd0, 32'd0, 2, 32'd53);          // read data, ready on 3rd access
    run_cmd(1'b0, 10'd0, 32'd0, TIMEOUT, 32'd99);    // timeout keeps 53
    run_cmd(1'b0, 10'd2, 32'd0, TIMEOUT - 1, 32'hCAFE_0001); // ready on last edge
    back_to_back();
    reset_mid_access();
    run_cmd(1'b0, 10'd4, 32'd0, 1, 32'h1234_5678);

    for (int i = 0; i < 25; i++) begin
      wr  = 1'($urandom);
      case ($urandom_range(0, 3))
        0: a = 10'd0;
        1: a = 10'd2;
        2: a = 10'd4;
        default: a = 10'($urandom);
      endcase
      dly = $urandom_range(0, TIMEOUT + 2);
      run_cmd(wr, a, $urandom, dly, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Bus initiator for the uart_binary register port. It turns single-word command requests from a local controller (CPU shim or sequencer) into two-phase register transfers: a setup cycle (sel=1, enable=0), then an access cycle (sel=1, enable=1).
- It waits for the peripheral's ready and returns the read data.
- It enforces a dummy idle gap between transfers and aborts a stalled access with an error response.

Parameters:
- GAP_CYCLES, 1, idle cycles with sel=0 after each transfer; legal range 1..15.
- TIMEOUT, 255, maximum access cycles waiting for ready before abort; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  the master accepts a command when this and cmd_valid are both high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  10 [11:2]  register word address (0 = data, 2 = T/R mode, 4 = baud divisor).
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle pulse at transfer completion.
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout abort.
- rsp_rdata  out  32  read data; valid with rsp_valid on a non-error read.
- sel  out  1  peripheral select.
- enable  out  1  access-phase strobe.
- write  out  1  transfer direction to the peripheral.
- addr  out  10 [11:2]  register address to the peripheral.
- data_out  out  32  write data to the peripheral.
- data_in  in  32  read data from the peripheral.
- ready  in  1  peripheral completes the access.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous) forces state IDLE and all outputs to 0, except cmd_ready=1.
- Timeout and gap counters clear on reset.
- States:
  - IDLE: cmd_ready=1; sel=0, enable=0; addr and data_out hold 0. A handshake latches cmd_write, cmd_addr and cmd_wdata, then goes to SETUP. cmd_ready is deasserted in every other state.
  - SETUP: exactly one cycle. sel=1, enable=0; addr, write and data_out are driven from the latched command. data_out=0 for reads. Then goes to ACCESS.
  - ACCESS: sel=1, enable=1; addr, write and data_out are held stable. Each cycle with ready=0 increments the timeout counter.
    - Rising edge with ready=1: rsp_rdata <= data_in (reads only; writes leave rsp_rdata unchanged), rsp_valid=1, rsp_err=0, then go to GAP.
    - If the counter reaches TIMEOUT with ready still 0: rsp_valid=1, rsp_err=1, rsp_rdata unchanged, then go to GAP.
    - If ready=1 on the same edge the counter would expire, it is a success, not a timeout.
  - GAP: sel=0, enable=0, addr=0, data_out=0 for GAP_CYCLES cycles, then IDLE.
- rsp_valid is high only in the first GAP cycle.
- Minimum transfer is 1 (accept) + 1 (setup) + 1 (access) + GAP_CYCLES, so back-to-back commands are spaced 3+GAP_CYCLES cycles apart.
- Changes to cmd_* after acceptance have no effect on the transfer in flight.
- ready and data_in are ignored outside ACCESS.
- Reset mid-transfer drops sel/enable immediately (asynchronously). No response is generated for the aborted command.

Test Plan:
- Write baud: cmd_write=1, cmd_addr=4, cmd_wdata=20, ready tied 1.
  - SETUP cycle shows sel=1, enable=0, addr=4, data_out=20.
  - Next cycle shows enable=1.
  - rsp_valid=1, rsp_err=0 one cycle later, then sel=0 for GAP_CYCLES.
- Read data register: cmd_write=0, cmd_addr=0; peripheral drives data_in=53 with ready asserted on the 3rd access cycle.
  - enable stays 1 for 3 cycles with addr stable.
  - rsp_rdata=53, rsp_err=0.
- Timeout, TIMEOUT=8, ready held 0.
  - enable=1 for 8 cycles.
  - rsp_valid=1, rsp_err=1; rsp_rdata keeps its prior value (53).
  - Returns to IDLE after the gap.
- Back-to-back commands: three commands with cmd_valid held high (addr 4 data 40, addr 2 data 2, addr 0 data 10), GAP_CYCLES=1.
  - Each is accepted exactly 4 cycles apart.
  - A sel=0 cycle separates every transfer.
  - Data and addresses are in order.
- Asynchronous reset asserted during ACCESS.
  - sel, enable, rsp_valid go to 0 without waiting for a clock edge; cmd_ready=1.
  - A new command after reset release completes normally.
- Boundary: ready=1 on the same edge the timeout counter reaches TIMEOUT → rsp_err=0 and data is captured.
